// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls ID until every read source is available.
// Define HAZARD_FWD_EN for a forwarding core (ALULAT/LOADLAT); otherwise WBLAT applies to every producer.
module hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int ADDRW   = 5,
  parameter int ZEROREG = 31,
  parameter int ALULAT  = 1,
  parameter int LOADLAT = 2,
  parameter int WBLAT   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             use_rn,
  input  logic             use_rm,
  input  logic             use_rt,
  input  logic [ADDRW-1:0] rn,
  input  logic [ADDRW-1:0] rm,
  input  logic [ADDRW-1:0] rt,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [ADDRW-1:0] id_rd,
  input  logic             flush,
  output logic             stall,
  output logic [NREGS-1:0] pending
);

`ifdef HAZARD_FWD_EN
  localparam int MAXLAT = (LOADLAT > ALULAT) ? LOADLAT : ALULAT;
`else
  localparam int MAXLAT = WBLAT;
`endif
  localparam int CW = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
  localparam logic [ADDRW:0]   NREGS_A = (ADDRW + 1)'(NREGS);
  localparam logic [ADDRW-1:0] ZERO_A  = ADDRW'(ZEROREG);
  // Only one latency set is meaningful per build; the other parameters are kept for a uniform interface.
  localparam int lat_unused = ALULAT + LOADLAT + WBLAT;

  logic          issue;
  logic [CW-1:0] load_val;

`ifdef HAZARD_FWD_EN
  localparam logic [CW-1:0] LD_VAL  = CW'(LOADLAT - 1);
  localparam logic [CW-1:0] ALU_VAL = CW'(ALULAT - 1);
  assign load_val = id_memread ? LD_VAL : ALU_VAL;
`else
  localparam logic [CW-1:0] WB_VAL = CW'(WBLAT - 1);
  logic memread_unused;
  assign memread_unused = id_memread;
  assign load_val = WB_VAL;
`endif

  // A source is busy only if it addresses a real, tracked register with a live countdown.
  function automatic logic busy(input logic [ADDRW-1:0] a, input logic [NREGS-1:0] pend);
    busy = ({1'b0, a} < NREGS_A) && (a != ZERO_A) && pend[a];
  endfunction

  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush) begin
      stall = (use_rn && busy(rn, pending)) ||
              (use_rm && busy(rm, pending)) ||
              (use_rt && busy(rt, pending));
    end
  end

  assign issue = id_valid && !stall && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_ent
      logic [CW-1:0] cnt_reg;
      if (gi == ZEROREG) begin : g_zero
        assign cnt_reg = '0;
      end else begin : g_track
        logic write_hit;
        assign write_hit = issue && id_regwrite && (id_rd == ADDRW'(gi));
        // The newest producer's latency replaces whatever is counting down (WAW).
        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_reg <= '0;
          end else if (write_hit) begin
            cnt_reg <= load_val;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
      end
      assign pending[gi] = (cnt_reg != '0);
    end
  endgenerate

endmodule
